// File: rtl/peripheral_interrupt_controller.sv
// Banked PIR/PIE interrupt flag/enable registers with a lowest-index-first priority encoder and an ack-time snapshot.
// Latency: a strobe in cycle t sets its flag at edge t+1, and the irq/pending outputs follow combinationally. There is no backpressure.
module peripheral_interrupt_controller #(
  parameter int         NUM_BANKS = 2,
  parameter logic [8:0] PIR_BASE  = 9'h00C,
  parameter logic [8:0] PIE_BASE  = 9'h08C,
  parameter bit         EDGE_MODE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8:0]             addr,
  input  logic                   wr_en,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  output logic                   addr_hit,
  input  logic [8*NUM_BANKS-1:0] interrupt_strobes,
  input  logic                   peie,
  output logic                   periph_irq,
  output logic                   pending_valid,
  output logic [4:0]             pending_index,
  input  logic                   irq_ack,
  output logic [4:0]             captured_index,
  output logic                   captured_valid
);

  localparam int N = 8 * NUM_BANKS;

  logic [NUM_BANKS-1:0][7:0] r_pir;
  logic [NUM_BANKS-1:0][7:0] r_pie;
  logic [N-1:0]              r_strobe_prev;
  logic [4:0]                r_cap_index;
  logic                      r_cap_valid;

  logic [NUM_BANKS-1:0][7:0] w_set;
  logic [N-1:0]              w_pend;
  logic [4:0]                w_index;
  logic                      w_hit;
  logic [7:0]                w_rdata;
  logic                      w_irq;

  // In edge mode only a 0->1 transition counts, so a held strobe cannot re-set a cleared flag.
  assign w_set  = EDGE_MODE ? (interrupt_strobes & ~r_strobe_prev) : interrupt_strobes;
  assign w_pend = r_pir & r_pie;

  always_comb begin
    w_hit   = 1'b0;
    w_rdata = 8'h00;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (addr == PIR_BASE + 9'(b)) begin
        w_hit   = 1'b1;
        w_rdata = r_pir[b];
      end
      if (addr == PIE_BASE + 9'(b)) begin
        w_hit   = 1'b1;
        w_rdata = r_pie[b];
      end
    end
  end

  // Scanning downward means the lowest set index is the one that remains.
  always_comb begin
    w_index = 5'd0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_pend[k]) w_index = 5'(k);
    end
  end

  assign w_irq = (|w_pend) & peie;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pir         <= '0;
      r_pie         <= '0;
      r_strobe_prev <= '0;
      r_cap_index   <= 5'd0;
      r_cap_valid   <= 1'b0;
    end else begin
      r_strobe_prev <= interrupt_strobes;
      for (int b = 0; b < NUM_BANKS; b++) begin
        // OR-ing the set term after the write data lets a hardware event win over a software clear.
        if (wr_en && (addr == PIR_BASE + 9'(b)))
          r_pir[b] <= data_in | w_set[b];
        else
          r_pir[b] <= r_pir[b] | w_set[b];
        if (wr_en && (addr == PIE_BASE + 9'(b)))
          r_pie[b] <= data_in;
      end
      if (irq_ack) begin
        r_cap_index <= w_index;
        r_cap_valid <= w_irq;
      end
    end
  end

  assign data_out       = w_rdata;
  assign addr_hit       = w_hit;
  assign periph_irq     = w_irq;
  assign pending_valid  = |w_pend;
  assign pending_index  = w_index;
  assign captured_index = r_cap_index;
  assign captured_valid = r_cap_valid;

endmodule
